// File: rtl/bcd_sum_apb_master.sv
// bcd_sum_apb_master
//   APB requester that drives the BCD summator slave on behalf of a datapath
//   client. One operand pair is taken on the cmd port. The block writes ARG1,
//   ARG2 and STATUS=1, polls RES with bounded retries, reads STATUS, and
//   returns the sum, the overflow flag and an error flag on the rsp port.
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   cmd_valid/ready, a/b    operand pair handshake (packed BCD)
//   rsp_valid/ready         result handshake
//   rsp_sum/ovf/err         RES value, STATUS[0], transfer failure
//   apb_*                   APB requester signals
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | cmd_ready high, waiting for an operand pair
// W_ARG1  | APB write of operand A to ARG1
// W_ARG2  | APB write of operand B to ARG2
// W_START | APB write of 1 to STATUS (starts the summator)
// R_RES   | APB read of RES; pslverr means "not ready yet"
// GAP     | idle bus cycles before the next RES read
// R_STAT  | APB read of STATUS for the overflow bit
// RESP    | rsp_valid high until rsp_ready

module bcd_sum_apb_master #(
  parameter int          ADDR_WIDTH    = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter int unsigned SUM_BASE_ADDR = 0,
  parameter int          MAX_RETRY     = 8,
  parameter int          RETRY_GAP     = 2,
  parameter int          TIMEOUT       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_sum,
  output logic                  rsp_ovf,
  output logic                  rsp_err,
  output logic                  apb_psel,
  output logic                  apb_penable,
  output logic                  apb_pwrite,
  output logic [ADDR_WIDTH-1:0] apb_paddr,
  output logic [DATA_WIDTH-1:0] apb_pwdata,
  input  logic [DATA_WIDTH-1:0] apb_prdata,
  input  logic                  apb_pready,
  input  logic                  apb_pslverr
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ARG1 = ADDR_WIDTH'(SUM_BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ARG2 = ADDR_WIDTH'(SUM_BASE_ADDR + BYTES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RES  = ADDR_WIDTH'(SUM_BASE_ADDR + 2 * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STAT = ADDR_WIDTH'(SUM_BASE_ADDR + 3 * BYTES);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int GW = $clog2(RETRY_GAP + 2);
  // The mandatory bus-idle cycle after ACCESS is the first gap cycle.
  localparam int GAP_LOAD = (RETRY_GAP > 1) ? RETRY_GAP - 1 : 0;

  typedef enum logic [2:0] {
    IDLE, W_ARG1, W_ARG2, W_START, R_RES, GAP, R_STAT, RESP
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_ACCESS, PH_IDLE} phase_t;

  state_t                state;
  phase_t                phase;
  logic [DATA_WIDTH-1:0] op_b;
  logic [TW-1:0]         tmo_cnt;
  logic [RW-1:0]         tries_left;
  logic [GW-1:0]         gap_cnt;

  function automatic logic is_bcd(input logic [DATA_WIDTH-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DATA_WIDTH / 4; i++)
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= PH_SETUP;
      op_b        <= '0;
      tmo_cnt     <= '0;
      tries_left  <= '0;
      gap_cnt     <= '0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_sum     <= '0;
      rsp_ovf     <= 1'b0;
      rsp_err     <= 1'b0;
      apb_psel    <= 1'b0;
      apb_penable <= 1'b0;
      apb_pwrite  <= 1'b0;
      apb_paddr   <= '0;
      apb_pwdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready  <= 1'b0;
            op_b       <= cmd_b;
            rsp_sum    <= '0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
            tries_left <= RW'(MAX_RETRY - 1);
            if (!is_bcd(cmd_a) || !is_bcd(cmd_b)) begin
              // Enters RESP with rsp_valid low; RESP raises it a cycle later.
              state   <= RESP;
              rsp_err <= 1'b1;
            end else begin
              state      <= W_ARG1;
              phase      <= PH_SETUP;
              apb_psel   <= 1'b1;
              apb_pwrite <= 1'b1;
              apb_paddr  <= ADDR_ARG1;
              apb_pwdata <= cmd_a;
            end
          end
        end

        W_ARG1, W_ARG2, W_START, R_RES, R_STAT: begin
          case (phase)
            PH_SETUP: begin
              apb_penable <= 1'b1;
              phase       <= PH_ACCESS;
              tmo_cnt     <= TW'(TIMEOUT - 1);
            end

            PH_ACCESS: begin
              if (apb_pready) begin
                apb_psel    <= 1'b0;
                apb_penable <= 1'b0;
                phase       <= PH_IDLE;
                case (state)
                  W_ARG1, W_ARG2, W_START: begin
                    if (apb_pslverr) begin
                      state     <= RESP;
                      phase     <= PH_SETUP;
                      rsp_err   <= 1'b1;
                      rsp_valid <= 1'b1;
                    end else if (state == W_ARG1) begin
                      state <= W_ARG2;
                    end else if (state == W_ARG2) begin
                      state <= W_START;
                    end else begin
                      state <= R_RES;
                    end
                  end
                  R_RES: begin
                    if (!apb_pslverr) begin
                      rsp_sum <= apb_prdata;
                      state   <= R_STAT;
                    end else if (tries_left == '0) begin
                      state     <= RESP;
                      phase     <= PH_SETUP;
                      rsp_err   <= 1'b1;
                      rsp_valid <= 1'b1;
                    end else begin
                      tries_left <= tries_left - RW'(1);
                      gap_cnt    <= GW'(GAP_LOAD);
                      state      <= GAP;
                    end
                  end
                  R_STAT: begin
                    // The bus-idle cycle of the last transfer is the first RESP cycle.
                    rsp_ovf   <= apb_prdata[0];
                    rsp_err   <= apb_pslverr;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                    phase     <= PH_SETUP;
                  end
                  default: state <= IDLE;
                endcase
              end else if (tmo_cnt == '0) begin
                apb_psel    <= 1'b0;
                apb_penable <= 1'b0;
                state       <= RESP;
                phase       <= PH_SETUP;
                rsp_err     <= 1'b1;
                rsp_valid   <= 1'b1;
              end else begin
                tmo_cnt <= tmo_cnt - TW'(1);
              end
            end

            PH_IDLE: begin
              // state already names the next transfer; launch its SETUP.
              phase    <= PH_SETUP;
              apb_psel <= 1'b1;
              case (state)
                W_ARG2: begin
                  apb_pwrite <= 1'b1;
                  apb_paddr  <= ADDR_ARG2;
                  apb_pwdata <= op_b;
                end
                W_START: begin
                  apb_pwrite <= 1'b1;
                  apb_paddr  <= ADDR_STAT;
                  apb_pwdata <= DATA_WIDTH'(1);
                end
                R_RES: begin
                  apb_pwrite <= 1'b0;
                  apb_paddr  <= ADDR_RES;
                  apb_pwdata <= '0;
                end
                default: begin
                  apb_pwrite <= 1'b0;
                  apb_paddr  <= ADDR_STAT;
                  apb_pwdata <= '0;
                end
              endcase
            end

            default: phase <= PH_SETUP;
          endcase
        end

        GAP: begin
          if (gap_cnt == '0) begin
            state      <= R_RES;
            phase      <= PH_SETUP;
            apb_psel   <= 1'b1;
            apb_pwrite <= 1'b0;
            apb_paddr  <= ADDR_RES;
            apb_pwdata <= '0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sum_apb_master.sv
// tb_bcd_sum_apb_master
//   Directed bench for bcd_sum_apb_master with a behavioural summator slave
//   (digit-wise BCD add, injectable RES errors and ARG2 stall) and a decimal
//   response model checked every cycle by a monitor process.

module tb_bcd_sum_apb_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_sum;
  logic        rsp_ovf, rsp_err;
  logic        apb_psel, apb_penable, apb_pwrite;
  logic [31:0] apb_paddr, apb_pwdata, apb_prdata;
  logic        apb_pready, apb_pslverr;

  always #5 clk = ~clk;

  bcd_sum_apb_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .SUM_BASE_ADDR(0),
    .MAX_RETRY(8), .RETRY_GAP(2), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- response model (decimal arithmetic) ----------------
  typedef struct packed {
    logic [31:0] sum;
    logic        ovf;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];

  function automatic bit nibbles_ok(input logic [31:0] v);
    for (int i = 0; i < 8; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint bcd_value(input logic [31:0] v);
    longint r = 0;
    for (int i = 7; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input longint n);
    logic [31:0] v = '0;
    longint      m = n;
    for (int i = 0; i < 8; i++) begin
      v[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return v;
  endfunction

  function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b, input bit bus_fail);
    rsp_t   r;
    longint s;
    r = '0;
    if (!nibbles_ok(a) || !nibbles_ok(b) || bus_fail) begin
      r.err = 1'b1;
    end else begin
      s     = bcd_value(a) + bcd_value(b);
      r.ovf = (s >= 64'd100000000);
      r.sum = to_bcd(s % 100000000);
    end
    return r;
  endfunction

  // ---------------- behavioural summator slave ----------------
  logic [31:0] s_arg1 = '0, s_arg2 = '0, s_res = '0, s_stat = '0;
  int          res_reads = 0;
  int          err_until = 0;
  bit          stall_en = 1'b0;
  logic [31:0] wr_log[$];

  function automatic logic [32:0] digit_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r = '0;
    int          c = 0;
    int          d;
    for (int i = 0; i < 8; i++) begin
      d = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
      if (d > 9) begin d = d - 10; c = 1; end else c = 0;
      r[4*i +: 4] = 4'(d);
    end
    r[32] = (c != 0);
    return r;
  endfunction

  assign apb_pready  = !(stall_en && apb_psel && apb_penable && apb_pwrite && apb_paddr == 32'd4);
  assign apb_pslverr = apb_psel && apb_penable && !apb_pwrite && apb_paddr == 32'd8 &&
                       (res_reads < err_until);
  assign apb_prdata  = (apb_paddr == 32'd8)  ? s_res  :
                       (apb_paddr == 32'd12) ? s_stat :
                       (apb_paddr == 32'd0)  ? s_arg1 : s_arg2;

  always @(posedge clk) begin
    if (!reset && apb_psel && apb_penable && apb_pready) begin
      if (apb_pwrite) begin
        wr_log.push_back(apb_paddr);
        case (apb_paddr)
          32'd0:  s_arg1 <= apb_pwdata;
          32'd4:  s_arg2 <= apb_pwdata;
          32'd12: if (apb_pwdata[0]) begin
                    s_res  <= digit_add(s_arg1, s_arg2)[31:0];
                    s_stat <= {31'b0, digit_add(s_arg1, s_arg2)[32]};
                  end
          default: ;
        endcase
      end else if (apb_paddr == 32'd8) begin
        res_reads <= res_reads + 1;
      end
    end
  end

  // ---------------- per-cycle monitor ----------------
  logic [31:0] cur_a = '0, cur_b = '0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  logic        prev_write = 1'b0, prev_psel = 1'b0;
  int          res_setups[$];
  int          stall_cycles = 0;
  int          n_setup = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (apb_penable) check("penable_without_psel", apb_psel, 1'b1);
      if (apb_psel && apb_penable && prev_psel) begin
        check("paddr_stable", apb_paddr, prev_addr);
        check("pwrite_stable", apb_pwrite, prev_write);
        check("pwdata_stable", apb_pwdata, prev_wdata);
      end
      if (apb_psel && apb_penable && apb_pready && apb_pwrite) begin
        check("write_addr_legal", apb_paddr inside {32'd0, 32'd4, 32'd12}, 1'b1);
        if (apb_paddr == 32'd0)  check("pwdata_arg1", apb_pwdata, cur_a);
        if (apb_paddr == 32'd4)  check("pwdata_arg2", apb_pwdata, cur_b);
        if (apb_paddr == 32'd12) check("pwdata_start", apb_pwdata, 32'd1);
      end
      if (cmd_ready) begin
        check("idle_psel_low", apb_psel, 1'b0);
        check("idle_rsp_low", rsp_valid, 1'b0);
      end
      if (apb_psel && !apb_penable) n_setup <= n_setup + 1;
      if (apb_psel && !apb_penable && apb_paddr == 32'd8) res_setups.push_back(cyc);
      if (apb_psel && apb_penable && !apb_pready) stall_cycles <= stall_cycles + 1;
      if (rsp_valid) begin
        check("rsp_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("model_rsp_err", rsp_err, exp_q[0].err);
          if (!exp_q[0].err) begin
            check("model_rsp_sum", rsp_sum, exp_q[0].sum);
            check("model_rsp_ovf", rsp_ovf, exp_q[0].ovf);
          end
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
    prev_psel  <= apb_psel;
    prev_addr  <= apb_paddr;
    prev_write <= apb_pwrite;
    prev_wdata <= apb_pwdata;
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit bus_fail,
                      output int t0);
    int n = 0;
    cur_a = a;
    cur_b = b;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    exp_q.push_back(model(a, b, bus_fail));
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    t0        = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int t0, input int exp_lat, input string name);
    int t = -1;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid) begin
        t = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    check({name, "_latency"}, 64'(t - t0), 64'(exp_lat));
  endtask

  task automatic rsp_drop(input string name);
    @(posedge clk); #1;
    check({name, "_rsp_dropped"}, rsp_valid, 1'b0);
  endtask

  initial begin
    int t0;
    int base;
    bit found;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", cmd_ready, 1'b0);
    check("reset_rsp", {rsp_valid, rsp_ovf, rsp_err, rsp_sum}, '0);
    check("reset_apb_ctl", {apb_psel, apb_penable, apb_pwrite}, '0);
    check("reset_apb_data", {apb_paddr, apb_pwdata}, '0);
    reset = 1'b0;
    check("ready_low_until_edge", cmd_ready, 1'b0);
    @(posedge clk); #1;
    check("ready_after_reset", cmd_ready, 1'b1);

    // simple sum
    wr_log.delete();
    send(32'h0000_0025, 32'h0000_0030, 1'b0, t0);
    wait_rsp(t0, 15, "simple");
    check("simple_sum", rsp_sum, 32'h0000_0055);
    check("simple_ovf", rsp_ovf, 1'b0);
    check("simple_err", rsp_err, 1'b0);
    check("simple_nwrites", wr_log.size(), 3);
    if (wr_log.size() == 3) check("simple_waddrs", {wr_log[0], wr_log[1], wr_log[2]}, {32'd0, 32'd4, 32'd12});
    rsp_drop("simple");

    // overflow sum
    send(32'h6030_8002, 32'h5140_6555, 1'b0, t0);
    wait_rsp(t0, 15, "ovf");
    check("ovf_sum", rsp_sum, 32'h1171_4557);
    check("ovf_ovf", rsp_ovf, 1'b1);
    check("ovf_err", rsp_err, 1'b0);
    rsp_drop("ovf");

    // non-BCD operand
    base = n_setup;
    send(32'h0000_000A, 32'h0000_0000, 1'b0, t0);
    wait_rsp(t0, 2, "nonbcd");
    check("nonbcd_err", rsp_err, 1'b1);
    check("nonbcd_no_psel", 64'(n_setup - base), 0);
    rsp_drop("nonbcd");

    // RES retry: first two reads answer pslverr
    err_until = res_reads + 2;
    res_setups.delete();
    send(32'h0000_1234, 32'h0000_8766, 1'b0, t0);
    wait_rsp(t0, 23, "retry");
    check("retry_sum", rsp_sum, 32'h0001_0000);
    check("retry_err", rsp_err, 1'b0);
    check("retry_res_setups", res_setups.size(), 3);
    for (int i = 1; i < res_setups.size(); i++)
      check("retry_setup_spacing", 64'(res_setups[i] - res_setups[i-1]), 4);
    rsp_drop("retry");

    // timeout on ARG2 write
    stall_en = 1'b1;
    base     = stall_cycles;
    send(32'h0000_0011, 32'h0000_0022, 1'b1, t0);
    wait_rsp(t0, 21, "timeout");
    check("timeout_psel", apb_psel, 1'b0);
    check("timeout_err", rsp_err, 1'b1);
    check("timeout_access_cycles", 64'(stall_cycles - base), 16);
    rsp_drop("timeout");
    stall_en = 1'b0;
    send(32'h0000_0011, 32'h0000_0022, 1'b0, t0);
    wait_rsp(t0, 15, "after_timeout");
    check("after_timeout_sum", rsp_sum, 32'h0000_0033);
    check("after_timeout_err", rsp_err, 1'b0);
    rsp_drop("after_timeout");

    // response backpressure
    rsp_ready = 1'b0;
    send(32'h0000_0099, 32'h0000_0001, 1'b0, t0);
    wait_rsp(t0, 15, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid_held", rsp_valid, 1'b1);
      check("bp_sum_held", rsp_sum, 32'h0000_0100);
      check("bp_flags_held", {rsp_ovf, rsp_err}, 2'b00);
      check("bp_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    rsp_drop("bp");

    // reset during W_START
    send(32'h0000_0001, 32'h0000_0002, 1'b0, t0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (apb_psel && apb_pwrite && apb_paddr == 32'd12) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("wstart_reached", found, 1'b1);
    check("wstart_cycle", 64'(cyc - t0), 7);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("midreset_psel", {apb_psel, apb_penable}, 2'b00);
    check("midreset_rsp_valid", rsp_valid, 1'b0);
    check("midreset_cmd_ready", cmd_ready, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midreset_ready_after", cmd_ready, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("midreset_no_rsp", rsp_valid, 1'b0);

    send(32'h0000_0045, 32'h0000_0045, 1'b0, t0);
    wait_rsp(t0, 15, "final");
    check("final_sum", rsp_sum, 32'h0000_0090);
    rsp_drop("final");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bcd_sum_apb_master.md
Name: bcd_sum_apb_master

Overview:
- APB requester stage that sits directly upstream of the BCD summator slave.
- Accepts a pair of packed-BCD operands on a valid/ready command port and runs the full summator register sequence over APB: write ARG1, write ARG2, write STATUS=1, poll RES, read STATUS.
- Returns sum, overflow and error on a valid/ready response port, so datapath clients never drive APB directly.

Parameters:
- ADDR_WIDTH, 32, APB address width.
- DATA_WIDTH, 32, APB data and operand width; must be a multiple of 4.
- SUM_BASE_ADDR, 0, summator base address. ARG1=+0, ARG2=+DATA_WIDTH/8, RES=+2*DATA_WIDTH/8, STATUS=+3*DATA_WIDTH/8.
- MAX_RETRY, 8, maximum number of RES reads attempted (initial read plus retries) before giving up.
- RETRY_GAP, 2, idle cycles inserted before each RES re-read.
- TIMEOUT, 16, maximum ACCESS cycles allowed with pready low.

Ports:
- clk  input  1  single clock; all logic updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  operand pair valid.
- cmd_ready  output  1  block idle and able to accept a command.
- cmd_a  input  DATA_WIDTH  packed-BCD operand 1.
- cmd_b  input  DATA_WIDTH  packed-BCD operand 2.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts the result.
- rsp_sum  output  DATA_WIDTH  BCD sum from RES.
- rsp_ovf  output  1  STATUS bit 0.
- rsp_err  output  1  transfer failed; rsp_sum and rsp_ovf are invalid when set.
- apb_psel  output  1  APB select.
- apb_penable  output  1  APB enable.
- apb_pwrite  output  1  APB direction; 1 = write.
- apb_paddr  output  ADDR_WIDTH  APB address.
- apb_pwdata  output  DATA_WIDTH  APB write data.
- apb_prdata  input  DATA_WIDTH  APB read data.
- apb_pready  input  1  slave ready.
- apb_pslverr  input  1  slave error.

Behaviour:
- Reset values: cmd_ready=0 while reset is high, then 1 in the first cycle after; rsp_valid=0; rsp_sum=0; rsp_ovf=0; rsp_err=0; apb_psel=0; apb_penable=0; apb_pwrite=0; apb_paddr=0; apb_pwdata=0. The FSM returns to IDLE.
- Reset asserted mid-sequence: the transfer is abandoned and psel/penable drop on the next edge. No response is produced.
- Sequencer states: IDLE, W_ARG1, W_ARG2, W_START, R_RES, GAP, R_STAT, RESP.
- Every bus state runs the APB sub-phases SETUP (psel=1, penable=0), then ACCESS (psel=1, penable=1), then one IDLE cycle (psel=0, penable=0).
- paddr, pwrite and pwdata are stable from SETUP through the end of ACCESS.
- ACCESS completes on the edge where pready=1. prdata and pslverr are sampled only on that edge.
- cmd_ready=1 only in IDLE. A handshake (cmd_valid & cmd_ready) latches both operands.
- BCD check at acceptance: if any nibble of cmd_a or cmd_b is greater than 9, go straight to RESP with rsp_err=1. No APB traffic is generated.
- W_ARG1 writes cmd_a; W_ARG2 writes cmd_b; W_START writes 1 to STATUS. pslverr=1 on any of these writes goes to RESP with rsp_err=1.
- R_RES reads RES:
  - pslverr=0: latch prdata into rsp_sum and go to R_STAT.
  - pslverr=1: increment the attempt counter; go to GAP for RETRY_GAP cycles, then R_RES again.
  - After MAX_RETRY failed reads: go to RESP with rsp_err=1.
- R_STAT reads STATUS: rsp_ovf = prdata[0]. pslverr=1 here sets rsp_err.
- Timeout: the ACCESS cycle counter resets at SETUP. If pready stays 0 for TIMEOUT consecutive ACCESS cycles:
  - psel and penable drop on the next edge;
  - go to RESP with rsp_err=1.
- RESP: rsp_valid=1 and the response fields are held stable until the rsp_ready handshake. On that handshake, rsp_valid drops on the next edge and the FSM returns to IDLE. rsp_valid is never asserted in any other state.
- Latency with a zero-wait slave and no retries: the command is accepted at cycle 0; each of the 5 transfers takes 3 cycles; rsp_valid=1 at cycle 15.
- One command is outstanding at a time. No pipelining across commands.

Test Plan:
- Simple sum: cmd 0x00000025 + 0x00000030 through the real summator -> APB writes to addresses 0, 4, 8+4=12 (STATUS, data 1); rsp_sum=0x00000055, rsp_ovf=0, rsp_err=0.
- Overflow sum: 0x60308002 + 0x51406555 -> rsp_sum=0x11714557, rsp_ovf=1, rsp_err=0.
- Non-BCD operand: cmd_a=0x0000000A -> rsp_err=1 two cycles after acceptance; apb_psel never asserted.
- Retry: behavioural slave returns pslverr=1 on the first two RES reads -> exactly 3 RES SETUPs, each retry preceded by 2 idle cycles; correct sum; rsp_err=0.
- Timeout: slave holds pready=0 on the ARG2 write -> after 16 ACCESS cycles, psel=0 and rsp_err=1. Next command completes normally.
- Backpressure and reset: rsp_ready held 0 for 10 cycles -> rsp_valid and fields stable, cmd_ready=0. Separately, asserting reset during W_START -> psel=0 next edge, rsp_valid=0, cmd_ready=1 the cycle after reset drops.
